// File: rtl/hcsr04_sampler.sv
// hcsr04_sampler: periodic HC-SR04 trigger scheduler with timeout and 2**AVG_LOG2-sample averaging.
// Optional range rejection of samples above MAX_MM is enabled by defining HCSR04_SAMPLER_RANGE_EN.
module hcsr04_sampler #(
   parameter int DW          = 12,
   parameter int PERIOD_CYC  = 3_000_000,
   parameter int TIMEOUT_CYC = 2_000_000,
   parameter int AVG_LOG2    = 2,
   parameter int MAX_MM      = 4000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   output logic          start_o,
   input  logic          val_i,
   input  logic [DW-1:0] distance_i,
   output logic [DW-1:0] out_data_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic          timeout_err_o,
   output logic          overrun_o
);
   localparam int PW = $clog2(PERIOD_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int AW = DW + AVG_LOG2;
   localparam logic [PW-1:0]       PERIOD_LAST = PW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0]       TMO_LAST    = TW'(TIMEOUT_CYC - 1);
   localparam logic [AVG_LOG2:0]   SMP_LAST    = (AVG_LOG2 + 1)'(2 ** AVG_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT, GAP} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     period_cnt_q, period_cnt_d;
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [AW-1:0]     acc_q, acc_d, acc_next;
   logic [AVG_LOG2:0] smp_cnt_q, smp_cnt_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              tmo_err_q, tmo_err_d;
   logic              overrun_q, overrun_d;
   logic              in_range, accept, avg_done;

`ifdef HCSR04_SAMPLER_RANGE_EN
   assign in_range = distance_i <= DW'(MAX_MM);
`else
   assign in_range = 1'b1;
`endif

   // Scheduler: both counters read 0 during FIRE, so start-to-start is exactly PERIOD_CYC.
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q + 1'b1;
      tmo_cnt_d    = tmo_cnt_q + 1'b1;
      accept       = 1'b0;
      tmo_err_d    = 1'b0;
      case (state_q)
         IDLE: state_d = en_i ? FIRE : IDLE;
         FIRE: state_d = WAIT;
         WAIT: begin
            if (val_i) begin
               accept    = in_range;
               tmo_err_d = !in_range;
               state_d   = GAP;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_err_d = 1'b1;
               state_d   = GAP;
            end
         end
         GAP:     state_d = (period_cnt_q == PERIOD_LAST) ? FIRE : GAP;
         default: state_d = IDLE;
      endcase
      if (!en_i) begin
         state_d   = IDLE;
         accept    = 1'b0;
         tmo_err_d = 1'b0;
      end
      if (state_d == FIRE) begin
         period_cnt_d = '0;
         tmo_cnt_d    = '0;
      end
   end

   // Averaging window and output register; a fresh average always wins over a consume.
   always_comb begin
      acc_next    = acc_q + AW'(distance_i);
      avg_done    = accept && (smp_cnt_q == SMP_LAST);
      acc_d       = (!en_i || avg_done) ? '0 : accept ? acc_next : acc_q;
      smp_cnt_d   = (!en_i || avg_done) ? '0 : accept ? smp_cnt_q + 1'b1 : smp_cnt_q;
      out_data_d  = avg_done ? acc_next[AW-1:AVG_LOG2] : out_data_q;
      out_valid_d = avg_done || (out_valid_q && !out_ready_i);
      overrun_d   = avg_done && out_valid_q && !out_ready_i;
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         period_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         acc_q        <= '0;
         smp_cnt_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         tmo_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         acc_q        <= acc_d;
         smp_cnt_q    <= smp_cnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         tmo_err_q    <= tmo_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign start_o       = state_q == FIRE;
   assign out_data_o    = out_data_q;
   assign out_valid_o   = out_valid_q;
   assign timeout_err_o = tmo_err_q;
   assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_hcsr04_sampler.sv
// tb_hcsr04_sampler: directed bench for hcsr04_sampler (honours HCSR04_SAMPLER_RANGE_EN).
module tb_hcsr04_sampler;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          en_i = 1'b0;
   logic          val_i = 1'b0;
   logic          out_ready_i = 1'b0;
   logic [DW-1:0] distance_i = '0;
   logic          start_o, out_valid_o, timeout_err_o, overrun_o;
   logic [DW-1:0] out_data_o;
   int            checks = 0, failures = 0, cyc = 0, t_now = 0, t_last = 0, n = 0;

   hcsr04_sampler #(
      .DW(DW), .PERIOD_CYC(100), .TIMEOUT_CYC(60), .AVG_LOG2(2), .MAX_MM(4000)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .start_o(start_o), .val_i(val_i),
      .distance_i(distance_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .timeout_err_o(timeout_err_o), .overrun_o(overrun_o)
   );

   // 20 ns clock and cycle index.
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_start(output int t);
      int k = 0;
      @(negedge clk);
      while (start_o !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("start_seen", start_o, 1);
      t = cyc;
   endtask

   task automatic measure(input int dly, input int d);
      wait_start(t_now);
      repeat (dly) @(negedge clk);
      val_i = 1'b1;
      distance_i = DW'(d);
      @(negedge clk);
      val_i = 1'b0;
      distance_i = '0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_start", start_o, 0);
      check("rst_valid", out_valid_o, 0);
      check("rst_data", out_data_o, 0);
      check("rst_tmo", timeout_err_o, 0);
      check("rst_ovr", overrun_o, 0);
      rst_ni = 1'b1;
      n = 0;
      repeat (500) begin @(negedge clk); if (start_o) n++; end
      check("idle_no_start", n, 0);
      check("idle_valid", out_valid_o, 0);

      en_i = 1'b1;
      measure(10, 100); t_last = t_now;
      measure(10, 200); check("period_a", t_now - t_last, 100); t_last = t_now;
      measure(10, 300); check("period_b", t_now - t_last, 100); t_last = t_now;
      check("valid_before_4th", out_valid_o, 0);
      measure(10, 401); check("period_c", t_now - t_last, 100); t_last = t_now;
      check("avg1_valid", out_valid_o, 1);
      check("avg1_data", out_data_o, 250);

      wait_start(t_now); check("period_d", t_now - t_last, 100); t_last = t_now;
      repeat (59) @(negedge clk);
      check("tmo_early", timeout_err_o, 0);
      @(negedge clk);
      check("tmo_pulse", timeout_err_o, 1);
      @(negedge clk);
      check("tmo_one_cycle", timeout_err_o, 0);
      measure(10, 400); check("period_after_tmo", t_now - t_last, 100);
      measure(10, 500);
      measure(10, 600);
      measure(10, 503);
      check("ovr_pulse", overrun_o, 1);
      check("ovr_data", out_data_o, 500);
      check("ovr_valid", out_valid_o, 1);
      @(negedge clk);
      check("ovr_one_cycle", overrun_o, 0);
      check("held_valid", out_valid_o, 1);
      out_ready_i = 1'b1;
      @(negedge clk);
      check("consumed", out_valid_o, 0);

      measure(59, 100);
      check("val_beats_tmo", timeout_err_o, 0);
      measure(20, 100);
      @(negedge clk);
      en_i = 1'b0;
      n = 0;
      repeat (150) begin @(negedge clk); if (start_o) n++; end
      check("disabled_no_start", n, 0);
      en_i = 1'b1;
      measure(5, 0);
      measure(5, 8);
      measure(5, 8);
      check("fresh_not_done", out_valid_o, 0);
      measure(5, 20);
      check("fresh_valid", out_valid_o, 1);
      check("fresh_avg", out_data_o, 9);

      out_ready_i = 1'b0;
      measure(5, 4001);
`ifdef HCSR04_SAMPLER_RANGE_EN
      check("range_tmo", timeout_err_o, 1);
      measure(5, 3); measure(5, 3); measure(5, 3); measure(5, 3);
      check("range_avg", out_data_o, 3);
`else
      check("range_tmo", timeout_err_o, 0);
      measure(5, 3); measure(5, 3); measure(5, 3);
      check("range_avg", out_data_o, 1002);
`endif
      check("range_valid", out_valid_o, 1);

      repeat (5) @(negedge clk);
      #3 rst_ni = 1'b0;
      #1;
      check("async_valid", out_valid_o, 0);
      check("async_data", out_data_o, 0);
      en_i = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      n = 0;
      repeat (200) begin @(negedge clk); if (start_o) n++; end
      check("post_rst_no_start", n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
